fifo_gen: RTL and testbench
===========================

FIFO_GEN -- requirements
Module: fifo_gen

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning data word width in bits (legal 1..64).
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning number of storage entries (legal 2..1024, any value, not only powers of two).
REQ-003 The block SHALL have parameter OVERWRITE, default 0, meaning full-write policy: 0 drops the incoming word, 1 overwrites the oldest word.
REQ-004 The block SHALL have parameter AFULL_LVL, default DEPTH-2, meaning the count at or above which afull asserts.
REQ-005 The block SHALL have parameter AEMPTY_LVL, default 2, meaning the count at or below which aempty asserts.
REQ-006 Ports SHALL be, with CW = clog2(DEPTH+1):
- clk  in  1  sole clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- wen  in  1  write request
- wdata  in  WIDTH  write data
- ren  in  1  read request
- rdata  out  WIDTH  registered read data
- rvalid  out  1  rdata holds a freshly popped word this cycle
- count  out  CW  current occupancy
- full, empty, afull, aempty  out  1  status flags
- ovf, udf  out  1  sticky overflow / underflow error flags
- dropped  out  1  one-cycle pulse: a stored word was lost this cycle
- err_clr  in  1  clears ovf and udf

Function
REQ-007 Write pointer, read pointer and count SHALL be independent registers; each pointer SHALL wrap from DEPTH-1 to 0.
REQ-008 A write SHALL be accepted when wen=1 and (count<DEPTH, or ren=1 with count>0, or OVERWRITE=1).
REQ-009 A read SHALL be accepted when ren=1 and count>0; the popped word SHALL appear on rdata with rvalid=1 exactly one cycle later.
REQ-010 When no read is accepted, rdata SHALL hold its last value and rvalid SHALL be 0.
REQ-011 Count SHALL increase by 1 on an accepted write without an accepted read, decrease by 1 on an accepted read without an accepted write, and otherwise hold.
REQ-012 When count==DEPTH and both wen and ren are set, both SHALL be accepted and count SHALL stay DEPTH.
REQ-013 When count==0 and both wen and ren are set:
- the write SHALL be accepted and the read rejected (no bypass);
- count SHALL become 1;
- udf SHALL set.
REQ-014 When count==DEPTH, wen=1, ren=0 and OVERWRITE=0: the word SHALL be discarded, pointers and count SHALL hold, ovf SHALL set, and dropped SHALL pulse.
REQ-015 When count==DEPTH, wen=1, ren=0 and OVERWRITE=1:
- the word SHALL be written at the write pointer;
- the read pointer SHALL advance by 1 and count SHALL stay DEPTH;
- ovf SHALL set and dropped SHALL pulse, because the oldest word is lost.
REQ-016 When ren=1 and count==0, udf SHALL set and the read pointer SHALL hold.
REQ-017 The status flags SHALL decode combinationally from count: full=(count==DEPTH), empty=(count==0), afull=(count>=AFULL_LVL), aempty=(count<=AEMPTY_LVL).
REQ-018 ovf and udf SHALL remain set until err_clr=1; if a set event and err_clr occur in the same cycle, the set SHALL win.
REQ-019 Storage SHALL be a DEPTH x WIDTH register array with one write and one read per cycle; stored contents SHALL have no reset requirement.

Reset
REQ-020 While rst=1 at a rising edge, the next state SHALL be: both pointers 0, count 0, rdata 0, rvalid 0, ovf 0, udf 0, dropped 0.
REQ-021 Any wen or ren presented while rst=1 SHALL be ignored.
REQ-022 Reset asserted mid-operation SHALL discard all stored words; empty=1 SHALL hold from the first cycle after reset.
REQ-023 During reset, empty=1, aempty=1, full=0 and afull=0, because the flags decode from count=0.

Verification
REQ-024 Fill and drain, DEPTH=16: write 0x01..0x10, then read 16 times -> rdata 0x01..0x10 in order, each one cycle after its ren; full=1 after the 16th write; empty=1 after the 16th read; ovf=udf=0.
REQ-025 Drop mode, OVERWRITE=0, DEPTH=4, full with A,B,C,D: write E -> dropped pulses once, ovf=1, count=4; four reads return A,B,C,D.
REQ-026 Overwrite mode, OVERWRITE=1, DEPTH=4, full with A,B,C,D: write E -> count=4, ovf=1; four reads return B,C,D,E.
REQ-027 Empty corner: count=0, wen=1 and ren=1 with wdata=0x5A -> count=1, udf=1, rvalid=0 next cycle; a following read returns 0x5A; err_clr then drops udf to 0.
REQ-028 Non-power-of-two depth, DEPTH=5: stream 37 words with random simultaneous wen/ren -> pointers wrap 4->0; output order matches a reference queue; count equals the pushed-minus-popped difference every cycle.
REQ-029 Mid-operation reset: with count=7, assert rst for one cycle -> count=0, empty=1, rvalid=0 next cycle; a subsequent write/read pair returns the new word.
REQ-030 Formal properties SHALL hold:
- count<=DEPTH;
- count never changes by more than 1 per cycle;
- full and empty are never both 1;
- dropped implies ovf on the next cycle.

Source files
------------

// File: rtl/fifo_gen.sv
// Synchronous FIFO with drop or overwrite-oldest policy on full, threshold flags
// and sticky overflow/underflow error reporting.
module fifo_gen #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int OVERWRITE  = 0,
  parameter int AFULL_LVL  = DEPTH - 2,
  parameter int AEMPTY_LVL = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wen,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         ren,
  output logic [WIDTH-1:0]             rdata,
  output logic                         rvalid,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         afull,
  output logic                         aempty,
  output logic                         ovf,
  output logic                         udf,
  output logic                         dropped,
  input  logic                         err_clr
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [PW-1:0] LAST     = PW'(DEPTH-1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr, rptr;
  logic             rd_ok, wr_ok, lose;

  assign full   = (count == FULL_CNT);
  assign empty  = (count == '0);
  assign afull  = (count >= CW'(AFULL_LVL));
  assign aempty = (count <= CW'(AEMPTY_LVL));

  assign rd_ok = ren && !empty;
  assign wr_ok = wen && (!full || rd_ok || (OVERWRITE != 0));
  // A write into a full FIFO with no read loses a word under either policy.
  assign lose    = wen && !ren && full;
  assign dropped = !rst && lose;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst && wr_ok) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      rdata  <= '0;
      rvalid <= 1'b0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      rvalid <= rd_ok;
      if (rd_ok) rdata <= mem[rptr];
      if (wr_ok) wptr <= inc(wptr);
      // Overwrite on full retires the oldest word by stepping the read side.
      if (rd_ok || (wr_ok && lose)) rptr <= inc(rptr);
      if (wr_ok && !rd_ok && !full) count <= count + CW'(1);
      else if (rd_ok && !wr_ok)     count <= count - CW'(1);
      ovf <= lose | (ovf & ~err_clr);
      udf <= (ren && empty) | (udf & ~err_clr);
    end
  end
endmodule

// File: tb/tb_fifo_gen.sv
// Bench for fifo_gen: four instances (16/drop, 4/drop, 4/overwrite, 5/drop), each
// checked every cycle against a queue model, plus directed literal expectations.
module tb_fifo_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic       wen[4], ren[4], err_clr[4];
  logic [7:0] wdata[4];
  logic [7:0] rdata[4];
  logic       rvalid[4], full[4], empty[4], afull[4], aempty[4], ovf[4], udf[4], dropped[4];
  logic [10:0] cnt[4];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h at %0t", nm, i, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : gi
    localparam int D  = (g == 0) ? 16 : (g == 3) ? 5 : 4;
    localparam int OV = (g == 2) ? 1 : 0;
    localparam int CW = $clog2(D+1);
    logic [CW-1:0] c;

    fifo_gen #(.WIDTH(8), .DEPTH(D), .OVERWRITE(OV)) u_dut (
      .clk(clk), .rst(rst), .wen(wen[g]), .wdata(wdata[g]), .ren(ren[g]),
      .rdata(rdata[g]), .rvalid(rvalid[g]), .count(c), .full(full[g]), .empty(empty[g]),
      .afull(afull[g]), .aempty(aempty[g]), .ovf(ovf[g]), .udf(udf[g]),
      .dropped(dropped[g]), .err_clr(err_clr[g])
    );
    assign cnt[g] = 11'(c);

    // Reference model: a queue holding the stored words, oldest first.
    logic [7:0] q[$];
    logic [7:0] m_rd = '0;
    bit m_rv = 0, m_ovf = 0, m_udf = 0;
    int n;
    bit rd_ok, set_o, set_u, m_drop;

    initial forever begin
      @(posedge clk);
      if (rst) begin
        q.delete();
        m_rd = '0; m_rv = 0; m_ovf = 0; m_udf = 0;
      end else begin
        n     = q.size();
        rd_ok = ren[g] && n > 0;
        set_u = ren[g] && n == 0;
        set_o = wen[g] && !ren[g] && n == D;
        m_rv  = rd_ok;
        if (rd_ok) begin
          m_rd = q[0];
          q.delete(0);
        end
        if (wen[g]) begin
          if (n < D || rd_ok) q.push_back(wdata[g]);
          else if (OV != 0) begin
            q.delete(0);
            q.push_back(wdata[g]);
          end
        end
        m_ovf = set_o || (m_ovf && !err_clr[g]);
        m_udf = set_u || (m_udf && !err_clr[g]);
      end
      #1;
      m_drop = !rst && wen[g] && !ren[g] && q.size() == D;
      chk("count",  g, cnt[g],     q.size());
      chk("full",   g, full[g],    q.size() == D);
      chk("empty",  g, empty[g],   q.size() == 0);
      chk("afull",  g, afull[g],   q.size() >= D - 2);
      chk("aempty", g, aempty[g],  q.size() <= 2);
      chk("rvalid", g, rvalid[g],  m_rv);
      chk("rdata",  g, rdata[g],   m_rd);
      chk("ovf",    g, ovf[g],     m_ovf);
      chk("udf",    g, udf[g],     m_udf);
      chk("dropped",g, dropped[g], m_drop);
    end
  end

  // One cycle of stimulus on instance i; returns at the following falling edge.
  task automatic op(input int i, input bit w, input logic [7:0] d, input bit r, input bit e);
    wen[i] = w; wdata[i] = d; ren[i] = r; err_clr[i] = e;
    @(posedge clk);
    @(negedge clk);
    wen[i] = 0; ren[i] = 0; err_clr[i] = 0;
  endtask

  task automatic fill4(input int i, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] d);
    op(i, 1, a, 0, 0); op(i, 1, b, 0, 0); op(i, 1, c, 0, 0); op(i, 1, d, 0, 0);
  endtask

  task automatic rd_expect(input int i, input logic [7:0] v);
    op(i, 0, 8'h00, 1, 0);
    chk("lit_rdata", i, rdata[i], v);
    chk("lit_rvalid", i, rvalid[i], 1);
  endtask

  initial begin
    int pushed, cyc;
    bit w, r;
    for (int i = 0; i < 4; i++) begin
      wen[i] = 0; ren[i] = 0; err_clr[i] = 0; wdata[i] = '0;
    end
    // Reset, with stray requests that must be ignored
    wen[0] = 1; ren[0] = 1; wdata[0] = 8'hFF;
    @(negedge clk);
    chk("rst_count",  0, cnt[0],    0);
    chk("rst_empty",  0, empty[0],  1);
    chk("rst_aempty", 0, aempty[0], 1);
    chk("rst_full",   0, full[0],   0);
    chk("rst_afull",  0, afull[0],  0);
    chk("rst_rdata",  0, rdata[0],  0);
    @(negedge clk);
    wen[0] = 0; ren[0] = 0;
    rst = 0;

    // Fill and drain, depth 16
    for (int k = 1; k <= 16; k++) op(0, 1, 8'(k), 0, 0);
    chk("fill_full",  0, full[0], 1);
    chk("fill_count", 0, cnt[0],  16);
    for (int k = 1; k <= 16; k++) rd_expect(0, 8'(k));
    chk("drain_empty", 0, empty[0], 1);
    chk("drain_ovf",   0, ovf[0],   0);
    chk("drain_udf",   0, udf[0],   0);

    // Drop mode, depth 4
    fill4(1, 8'hAA, 8'hBB, 8'hCC, 8'hDD);
    wen[1] = 1; wdata[1] = 8'hEE;
    #1 chk("drop_pulse", 1, dropped[1], 1);
    @(posedge clk);
    @(negedge clk);
    wen[1] = 0;
    #1 chk("drop_end", 1, dropped[1], 0);
    chk("drop_count", 1, cnt[1], 4);
    chk("drop_ovf",   1, ovf[1], 1);
    @(negedge clk);
    rd_expect(1, 8'hAA); rd_expect(1, 8'hBB); rd_expect(1, 8'hCC); rd_expect(1, 8'hDD);

    // Overwrite mode, depth 4
    fill4(2, 8'hAA, 8'hBB, 8'hCC, 8'hDD);
    op(2, 1, 8'hEE, 0, 0);
    chk("ovw_count", 2, cnt[2], 4);
    chk("ovw_ovf",   2, ovf[2], 1);
    rd_expect(2, 8'hBB); rd_expect(2, 8'hCC); rd_expect(2, 8'hDD); rd_expect(2, 8'hEE);

    // Empty corner: simultaneous write and read on empty FIFO
    op(1, 1, 8'h5A, 1, 0);
    chk("ecor_count",  1, cnt[1],    1);
    chk("ecor_udf",    1, udf[1],    1);
    chk("ecor_rvalid", 1, rvalid[1], 0);
    rd_expect(1, 8'h5A);
    op(1, 0, 8'h00, 0, 1);
    chk("clr_udf", 1, udf[1], 0);
    chk("clr_ovf", 1, ovf[1], 0);

    // Full with simultaneous write and read: both accepted, no overflow
    fill4(1, 8'h11, 8'h12, 8'h13, 8'h14);
    op(1, 1, 8'h15, 1, 0);
    chk("fullrw_count", 1, cnt[1],   4);
    chk("fullrw_rdata", 1, rdata[1], 8'h11);
    chk("fullrw_ovf",   1, ovf[1],   0);
    rd_expect(1, 8'h12); rd_expect(1, 8'h13); rd_expect(1, 8'h14); rd_expect(1, 8'h15);

    // Depth 5 streaming with random simultaneous traffic
    pushed = 0;
    cyc = 0;
    while (pushed < 37 && cyc < 400) begin
      w = ($urandom_range(0, 2) != 0);
      r = ($urandom_range(0, 1) != 0);
      op(3, w, 8'(8'h40 + pushed), r, 0);
      if (w) pushed++;
      cyc++;
    end
    chk("stream_done", 3, pushed, 37);
    repeat (6) op(3, 0, 8'h00, 1, 0);
    chk("stream_empty", 3, empty[3], 1);
    op(3, 0, 8'h00, 0, 1);

    // Mid-operation reset with 7 stored words
    for (int k = 0; k < 7; k++) op(0, 1, 8'(8'h61 + k), 0, 0);
    chk("mid_count", 0, cnt[0], 7);
    rst = 1;
    @(posedge clk);
    #1;
    chk("mrst_count",  0, cnt[0],    0);
    chk("mrst_empty",  0, empty[0],  1);
    chk("mrst_rvalid", 0, rvalid[0], 0);
    @(negedge clk);
    rst = 0;
    op(0, 1, 8'h77, 0, 0);
    rd_expect(0, 8'h77);
    op(0, 0, 8'h00, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: stimulus did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end
endmodule
